// File: rtl/mem_access_unit.sv
// Load/store initiator for an external byte-lane memory.
// It takes one request at a time and expands it into four 10-bit byte-address
// lanes, four write-data bytes and a 3-bit write control. Loads capture the
// combinational read bus at the end of ISSUE and are zero- or sign-extended.
// Out-of-range or reserved-size requests fault and never write memory.
module mem_access_unit #(
    parameter int MemSize = 49
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic [2:0]  control,
    output logic [39:0] Address,
    output logic [7:0]  DW0,
    output logic [7:0]  DW1,
    output logic [7:0]  DW2,
    output logic [7:0]  DW3,
    input  logic [31:0] Read,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_fault
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t      state_reg;
    logic [1:0]  size_reg;
    logic        store_reg;
    logic        signed_reg;
    logic        fault_reg;

    logic        accept;
    logic [2:0]  nbytes_next;
    logic [10:0] last_byte_next;
    logic        fault_next;
    logic [2:0]  control_next;
    logic [39:0] lane_next;
    logic [31:0] load_ext;

    assign accept = req_valid && req_ready;

    // Number of bytes touched by the incoming request; reserved size counts as one.
    always_comb begin
        case (req_size)
            2'd0:    nbytes_next = 3'd1;
            2'd1:    nbytes_next = 3'd2;
            2'd2:    nbytes_next = 3'd4;
            default: nbytes_next = 3'd1;
        endcase
    end

    // Last byte is computed in 11 bits so an address near 1023 cannot wrap back into range.
    assign last_byte_next = {1'b0, req_addr} + {8'd0, nbytes_next} - 11'd1;
    assign fault_next     = (req_size == 2'd3) || (last_byte_next >= 11'(MemSize));
    assign control_next   = (req_store && !fault_next) ? ({1'b0, req_size} + 3'd1) : 3'd0;

    // Little-endian lanes; lanes beyond the access width repeat A0 so that the
    // read bus only depends on bytes actually accessed.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_next[gi*10 +: 10] = (3'(gi) < nbytes_next) ? (req_addr + 10'(gi)) : req_addr;
        end
    endgenerate

    // Zero/sign extension of the captured read bus according to the registered size.
    always_comb begin
        case (size_reg)
            2'd0:    load_ext = signed_reg ? {{24{Read[7]}}, Read[7:0]}   : {24'd0, Read[7:0]};
            2'd1:    load_ext = signed_reg ? {{16{Read[15]}}, Read[15:0]} : {16'd0, Read[15:0]};
            default: load_ext = Read;
        endcase
    end

    // Request FSM with registered memory-side and response-side outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            size_reg   <= 2'd0;
            store_reg  <= 1'b0;
            signed_reg <= 1'b0;
            fault_reg  <= 1'b0;
            req_ready  <= 1'b1;
            control    <= 3'd0;
            Address    <= 40'd0;
            DW0        <= 8'd0;
            DW1        <= 8'd0;
            DW2        <= 8'd0;
            DW3        <= 8'd0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 32'd0;
            rsp_fault  <= 1'b0;
        end else begin
            case (state_reg)
                ISSUE: begin
                    // End of the memory cycle: drop the lanes, sample Read, respond.
                    control   <= 3'd0;
                    Address   <= 40'd0;
                    DW0       <= 8'd0;
                    DW1       <= 8'd0;
                    DW2       <= 8'd0;
                    DW3       <= 8'd0;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_fault <= fault_reg;
                    rsp_data  <= (fault_reg || store_reg) ? 32'd0 : load_ext;
                    state_reg <= DONE;
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    rsp_valid <= 1'b0;
                    if (accept) begin
                        size_reg   <= req_size;
                        store_reg  <= req_store;
                        signed_reg <= req_signed;
                        fault_reg  <= fault_next;
                        req_ready  <= 1'b0;
                        control    <= control_next;
                        Address    <= lane_next;
                        DW0        <= req_wdata[7:0];
                        DW1        <= req_wdata[15:8];
                        DW2        <= req_wdata[23:16];
                        DW3        <= req_wdata[31:24];
                        state_reg  <= ISSUE;
                    end else begin
                        state_reg  <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
